// File: rtl/stream_rr_merge_if.sv
// Handshake bundle for the round-robin stream merge: N upstream lanes in, one tagged stream out.
// The master modport is the merge itself; slave is the surrounding producers/consumer.
interface stream_rr_merge_if #(
    parameter int N = 2,
    parameter int W = 8
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/stream_rr_merge.sv
// Round-robin merge of N token streams into one registered output slot, with burst hold
// that keeps the grant on one requester for up to MAX_BURST consecutive tokens.
module stream_rr_merge #(
    parameter int N         = 2,
    parameter int W         = 8,
    parameter int MAX_BURST = 2
) (
    input  logic               clk,
    input  logic               nrst,
    stream_rr_merge_if.master  bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [SW-1:0] out_src_q;
    logic [SW-1:0] ptr;
    logic [3:0]    cnt;

    logic [W-1:0]  lane_data [N];
    logic          load_en, hold, any, found;
    logic [SW-1:0] pick, sel;
    int            idx;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_data[i]    = bus.in_data[i*W +: W];
        assign bus.in_ready[i] = load_en && any && nrst && (sel == SW'(i));
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign hold    = (cnt != 4'd0) && (cnt < 4'(MAX_BURST)) && bus.in_valid[ptr];
    assign any     = hold || (|bus.in_valid);
    assign sel     = hold ? ptr : pick;

    // Search starts just after the last grant so ptr itself is considered last.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr         <= SW'(N - 1);
            cnt         <= 4'd0;
        end else if (load_en) begin
            if (any) begin
                out_valid_q <= 1'b1;
                out_data_q  <= lane_data[sel];
                out_src_q   <= sel;
                ptr         <= sel;
                cnt         <= (sel == ptr && cnt != 4'd0 && cnt < 4'(MAX_BURST)) ? cnt + 4'd1 : 4'd1;
            end else begin
                // A gap ends the burst; the next grant starts fresh.
                out_valid_q <= 1'b0;
                cnt         <= 4'd0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_stream_rr_merge.sv
// Directed bench for stream_rr_merge: one instance with MAX_BURST=2, one with MAX_BURST=1,
// both fed identical control, each lane supplying an incrementing token sequence.
module tb_stream_rr_merge;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    stream_rr_merge_if #(.N(2), .W(8)) ifa ();
    stream_rr_merge_if #(.N(2), .W(8)) ifb ();

    stream_rr_merge #(.N(2), .W(8), .MAX_BURST(2)) dut_a (.clk(clk), .nrst(nrst), .bus(ifa));
    stream_rr_merge #(.N(2), .W(8), .MAX_BURST(1)) dut_b (.clk(clk), .nrst(nrst), .bus(ifb));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ctr_a [2];
    logic [7:0] ctr_b [2];
    logic [1:0] rdy_a, rdy_b;

    task automatic drive_data();
        ifa.in_data = {ctr_a[1], ctr_a[0]};
        ifb.in_data = {ctr_b[1], ctr_b[0]};
    endtask

    task automatic set_ctl(input logic [1:0] v, input logic ordy);
        ifa.in_valid  = v;
        ifb.in_valid  = v;
        ifa.out_ready = ordy;
        ifb.out_ready = ordy;
    endtask

    // One clock: sample readies mid-cycle, advance lane counters on accepted tokens,
    // return just after the rising edge so outputs can be checked.
    task automatic cycle();
        logic [1:0] acc_a, acc_b;
        @(negedge clk);
        rdy_a = ifa.in_ready;
        rdy_b = ifb.in_ready;
        acc_a = ifa.in_valid & ifa.in_ready;
        acc_b = ifb.in_valid & ifb.in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_a[i]) ctr_a[i] = ctr_a[i] + 8'd1;
            if (acc_b[i]) ctr_b[i] = ctr_b[i] + 8'd1;
        end
        drive_data();
    endtask

    task automatic do_reset(input logic [7:0] c0, input logic [7:0] c1);
        nrst = 1'b0;
        ctr_a[0] = c0; ctr_a[1] = c1;
        ctr_b[0] = c0; ctr_b[1] = c1;
        drive_data();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        set_ctl(2'b11, 1'b1);
        nrst = 1'b0;
        ctr_a[0] = 8'h00; ctr_a[1] = 8'h80;
        ctr_b[0] = 8'h00; ctr_b[1] = 8'h80;
        drive_data();
        repeat (2) cycle();
        n_checks++;
        if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ifa.out_valid); end
        n_checks++;
        if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL reset_in_ready got %b want 00", rdy_a); end
        n_checks++;
        if (ifa.out_data !== 8'h00 || ifa.out_src !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_slot got data %h src %0d want 00/0", ifa.out_data, ifa.out_src);
        end
        nrst = 1'b1;
        cycle();
        n_checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_src !== 1'b0 || ifa.out_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_first_grant got v %b src %0d data %h want 1/0/00", ifa.out_valid, ifa.out_src, ifa.out_data);
        end
    endtask

    task automatic test_single_source();
        set_ctl(2'b01, 1'b1);
        do_reset(8'h10, 8'hA0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (rdy_a !== 2'b01) begin n_fail++; $display("FAIL single_ready[%0d] got %b want 01", k, rdy_a); end
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'h10 + 8'(k) || ifa.out_src !== 1'b0) begin
                n_fail++;
                $display("FAIL single_out[%0d] got v %b data %h src %0d want 1/%h/0", k, ifa.out_valid, ifa.out_data, ifa.out_src, 8'h10 + 8'(k));
            end
        end
        set_ctl(2'b00, 1'b1);
        cycle();
        n_checks++;
        if (ifa.out_valid !== 1'b0 || rdy_a !== 2'b00) begin
            n_fail++; $display("FAIL single_gap got v %b rdy %b want 0/00", ifa.out_valid, rdy_a);
        end
    endtask

    task automatic test_burst_rotation();
        logic [7:0] exp_d [6];
        logic       exp_s [6];
        exp_d = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03};
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        set_ctl(2'b11, 1'b1);
        do_reset(8'h00, 8'h80);
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_src !== exp_s[k] || ifa.out_data !== exp_d[k]) begin
                n_fail++;
                $display("FAIL burst[%0d] got src %0d data %h want src %0d data %h", k, ifa.out_src, ifa.out_data, exp_s[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic       exp_s [4];
        exp_d = '{8'h00, 8'h80, 8'h01, 8'h81};
        exp_s = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_ctl(2'b11, 1'b1);
        do_reset(8'h00, 8'h80);
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (ifb.out_valid !== 1'b1 || ifb.out_src !== exp_s[k] || ifb.out_data !== exp_d[k]) begin
                n_fail++;
                $display("FAIL rr[%0d] got src %0d data %h want src %0d data %h", k, ifb.out_src, ifb.out_data, exp_s[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_d [3];
        logic       exp_s [3];
        exp_d = '{8'h02, 8'h03, 8'h82};
        exp_s = '{1'b0, 1'b0, 1'b1};
        set_ctl(2'b11, 1'b1);
        do_reset(8'h00, 8'h80);
        repeat (4) cycle();
        n_checks++;
        if (ifa.out_data !== 8'h81 || ifa.out_src !== 1'b1) begin
            n_fail++; $display("FAIL bp_setup got data %h src %0d want 81/1", ifa.out_data, ifa.out_src);
        end
        set_ctl(2'b11, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (rdy_a !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 00", k, rdy_a); end
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'h81 || ifa.out_src !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d] got v %b data %h src %0d want 1/81/1", k, ifa.out_valid, ifa.out_data, ifa.out_src);
            end
        end
        set_ctl(2'b11, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (ifa.out_src !== exp_s[k] || ifa.out_data !== exp_d[k]) begin
                n_fail++;
                $display("FAIL bp_resume[%0d] got src %0d data %h want src %0d data %h", k, ifa.out_src, ifa.out_data, exp_s[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic exp_s [3];
        logic [7:0] exp_d [3];
        exp_s = '{1'b0, 1'b0, 1'b1};
        exp_d = '{8'h01, 8'h02, 8'h80};
        set_ctl(2'b11, 1'b1);
        do_reset(8'h00, 8'h80);
        cycle();
        n_checks++;
        if (ifa.out_src !== 1'b0 || ifa.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_setup got v %b src %0d want 1/0", ifa.out_valid, ifa.out_src);
        end
        #1;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 2'b00) begin
            n_fail++; $display("FAIL areset_immediate got v %b rdy %b want 0/00", ifa.out_valid, ifa.in_ready);
        end
        cycle();
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_src !== exp_s[k] || ifa.out_data !== exp_d[k]) begin
                n_fail++;
                $display("FAIL areset_restart[%0d] got src %0d data %h want src %0d data %h", k, ifa.out_src, ifa.out_data, exp_s[k], exp_d[k]);
            end
        end
    endtask

    initial begin
        ifa.in_valid = '0; ifb.in_valid = '0;
        ifa.in_data = '0;  ifb.in_data = '0;
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
        test_reset();
        test_single_source();
        test_burst_rotation();
        test_round_robin();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
